debounce_event: RTL and testbench
=================================

Name: debounce_event

Overview:
- Multi-channel switch/button conditioner for board I/O in the FPGA top level.
- Each channel goes through the same steps: input synchronizer, shared sample prescaler, per-channel stability counter, then registered debounced level.
- New over the single-purpose debouncer: one-cycle press and release pulses, long-press detection, and an input synchronizer.
- Sits between raw pins and control logic, e.g. the start button or the mode switches.

Parameters:
- W, 1, number of independent channels.
- SYNC_STAGES, 2, flip-flop synchronizer depth per channel; minimum 2.
- TICK_W, 12, prescaler width; one sample tick every 2^TICK_W clk cycles.
- STABLE_N, 3, consecutive differing ticks needed to change state; range 2..255.
- LONG_N, 64, ticks the level must stay high before the long-press pulse; range 1..2^LONG_W-1.
- LONG_W, 8, long-press counter width.

Ports:
- clk  in  1  system clock.
- rst_async  in  1  asynchronous reset, active-high.
- switch_i  in  W  raw, asynchronous switch inputs.
- level_o  out  W  debounced level.
- rise_o  out  W  one-clk pulse when level_o goes 0->1.
- fall_o  out  W  one-clk pulse when level_o goes 1->0.
- long_o  out  W  one-clk pulse when level has been high for LONG_N ticks.
- tick_o  out  1  prescaler tick, exported for debug and for the bench.

Behaviour:
- Reset: all synchronizer flops, the prescaler, all counters and all outputs go to 0. Reset is asynchronous on assert and is used synchronously on release. A reset in the middle of a debounce or long-press discards the pending count; no pulse is emitted.
- Synchronizer: sync[k] is switch_i[k] delayed by SYNC_STAGES clk cycles.
- Prescaler: free-running TICK_W-bit counter that increments every clk and wraps. tick is high for the cycle in which the counter equals 0.
- Per channel, on a tick:
  - If sync != level: stab_cnt increments.
    - When stab_cnt == STABLE_N-1 before the increment, level toggles, stab_cnt resets to 0, and the matching rise or fall flop is set for that one cycle.
  - If sync == level: stab_cnt resets to 0.
  - A glitch shorter than STABLE_N consecutive ticks never changes level.
- Outside tick cycles, stab_cnt, level and long_cnt hold their values.
- rise_o, fall_o and long_o are cleared on every clk that does not set them, so each pulse is exactly 1 clk wide.
- Edge pulses are registered and appear in the same cycle that the new level_o value first appears.
- Long-press:
  - While level is 1, each tick increments long_cnt, saturating at LONG_N.
  - On the tick where long_cnt goes from LONG_N-1 to LONG_N, long_o pulses once. It does not repeat while the channel stays high.
  - long_cnt clears to 0 on the cycle level falls.
  - A level that rises and falls before LONG_N ticks produces no long_o.
- Simultaneous events: when level toggles on a tick, long_cnt takes its new value from the post-toggle level. On rise it starts at 0 and first increments on the next tick. On fall it clears.
- Latency from a stable input change to level_o: between SYNC_STAGES + (STABLE_N-1)*2^TICK_W + 1 and SYNC_STAGES + STABLE_N*2^TICK_W + 1 clk cycles, depending on prescaler phase.
- Channels are fully independent. Any combination may pulse in the same cycle.
- stab_cnt width is $clog2(STABLE_N)+1. No counter may wrap except the prescaler.

Decomposition:
- Package debounce_pkg holds:
  - the stability-counter width function;
  - the default constants for TICK_W, STABLE_N and LONG_N;
  - a simulation-only override TICK_W_SIM = 2.
- Sub-module debounce_chan: one channel containing sync chain, stab_cnt, level, long_cnt and pulse flops. Its inputs are clk, rst_async, tick and the raw bit.
- The top instantiates W copies of debounce_chan via generate, plus a single shared prescaler.

Test Plan (TICK_W=2, STABLE_N=3, LONG_N=4, SYNC_STAGES=2, W=2):
- Reset release with both inputs 0 -> all outputs 0; tick_o pulses every 4 clk.
- Raw 1 held on ch0 -> rise_o[0] is a 1-clk pulse; level_o[0]=1 within 2+8+1..2+12+1 clk. ch1 outputs stay 0.
- ch0 high glitch lasting 2 ticks, then 0 -> no rise_o, level_o[0] stays 0.
- ch0 held high for 4 ticks after rise -> exactly one long_o[0] pulse. Then hold 10 more ticks -> no further long_o. Then release -> fall_o[0] pulse, long_cnt cleared.
- Both channels driven high in the same clk -> rise_o=2'b11 in the same cycle.
- rst_async asserted with stab_cnt=2 mid-debounce -> outputs 0 immediately (asynchronously), no pulse after release, and debounce restarts from 0.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the multi-channel switch debouncer.
package debounce_pkg;

    // Production defaults
    localparam int unsigned TICK_W_DEF   = 12;
    localparam int unsigned STABLE_N_DEF = 3;
    localparam int unsigned LONG_N_DEF   = 64;

    // Short prescaler so simulations reach a tick every few clocks
    localparam int unsigned TICK_W_SIM   = 2;

    // Stability counter width; one spare bit so the counter never wraps
    function automatic int unsigned stab_cnt_w(input int unsigned stable_n);
        return $clog2(stable_n) + 1;
    endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: synchronizer, stability counter, debounced level,
// long-press counter and registered one-clock event pulses.
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned STABLE_N    = STABLE_N_DEF,
    parameter int unsigned LONG_N      = LONG_N_DEF,
    parameter int unsigned LONG_W      = 8
) (
    input  logic clk,
    input  logic rst_async,
    input  logic tick_i,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic long_o
);

    localparam int unsigned       StabW    = stab_cnt_w(STABLE_N);
    localparam logic [StabW-1:0]  StabLast = StabW'(STABLE_N - 1);
    localparam logic [LONG_W-1:0] LongMax  = LONG_W'(LONG_N);
    localparam logic [LONG_W-1:0] LongLast = LONG_W'(LONG_N - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_bit;
    logic [StabW-1:0]       stab_q, stab_d;
    logic                   level_q, level_d;
    logic [LONG_W-1:0]      long_cnt_q, long_cnt_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   long_q, long_d;

    assign sync_bit = sync_q[SYNC_STAGES-1];

    // Metastability chain: raw bit shifted in, oldest stage used
    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
        end
    end

    // Next-state: debounce and long-press only advance on prescaler ticks
    always_comb begin
        stab_d     = stab_q;
        level_d    = level_q;
        long_cnt_d = long_cnt_q;
        rise_d     = 1'b0;
        fall_d     = 1'b0;
        long_d     = 1'b0;
        if (tick_i) begin
            if (sync_bit != level_q) begin
                if (stab_q == StabLast) begin
                    level_d = ~level_q;
                    stab_d  = '0;
                    rise_d  = ~level_q;
                    fall_d  = level_q;
                end else begin
                    stab_d = stab_q + 1'b1;
                end
            end else begin
                stab_d = '0;
            end
            // A toggle restarts long-press timing from the new level
            if (level_d != level_q) begin
                long_cnt_d = '0;
            end else if (level_q && (long_cnt_q != LongMax)) begin
                long_cnt_d = long_cnt_q + 1'b1;
                long_d     = (long_cnt_q == LongLast);
            end
        end
    end

    // State and pulse registers
    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            stab_q     <= '0;
            level_q    <= 1'b0;
            long_cnt_q <= '0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            long_q     <= 1'b0;
        end else begin
            stab_q     <= stab_d;
            level_q    <= level_d;
            long_cnt_q <= long_cnt_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            long_q     <= long_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;
    assign long_o  = long_q;

endmodule

// File: rtl/debounce_event.sv
// Multi-channel switch conditioner: one shared sample prescaler feeding
// W independent debounce channels with press/release/long-press pulses.
module debounce_event
    import debounce_pkg::*;
#(
    parameter int unsigned W           = 1,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TICK_W      = TICK_W_DEF,
    parameter int unsigned STABLE_N    = STABLE_N_DEF,
    parameter int unsigned LONG_N      = LONG_N_DEF,
    parameter int unsigned LONG_W      = 8
) (
    input  logic         clk,
    input  logic         rst_async,
    input  logic [W-1:0] switch_i,
    output logic [W-1:0] level_o,
    output logic [W-1:0] rise_o,
    output logic [W-1:0] fall_o,
    output logic [W-1:0] long_o,
    output logic         tick_o
);

    logic [TICK_W-1:0] presc_q, presc_d;
    logic              tick;

    // Free-running prescaler; wraps naturally
    always_comb begin
        presc_d = presc_q + 1'b1;
    end

    // Prescaler register
    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    // Masked during reset so tick_o reads 0 while the counter is held at 0
    assign tick   = (presc_q == '0) && !rst_async;
    assign tick_o = tick;

    for (genvar k = 0; k < W; k++) begin : g_chan
        debounce_chan #(
            .SYNC_STAGES(SYNC_STAGES),
            .STABLE_N   (STABLE_N),
            .LONG_N     (LONG_N),
            .LONG_W     (LONG_W)
        ) u_chan (
            .clk      (clk),
            .rst_async(rst_async),
            .tick_i   (tick),
            .raw_i    (switch_i[k]),
            .level_o  (level_o[k]),
            .rise_o   (rise_o[k]),
            .fall_o   (fall_o[k]),
            .long_o   (long_o[k])
        );
    end

endmodule

// File: tb/tb_debounce_event.sv
// Bench for debounce_event: table-driven segments with hand-derived results,
// a reset-during-debounce sequence, and a random run against a tick-level model.
module tb_debounce_event;
    import debounce_pkg::*;

    localparam int W      = 2;
    localparam int SYNC   = 2;
    localparam int STABLE = 3;
    localparam int LONGN  = 4;
    localparam int TickP  = 1 << TICK_W_SIM;

    logic         clk = 1'b0;
    logic         rst_async = 1'b1;
    logic [W-1:0] switch_i = '0;
    logic [W-1:0] level_o, rise_o, fall_o, long_o;
    logic         tick_o;

    always #5 clk = ~clk;

    debounce_event #(
        .W          (W),
        .SYNC_STAGES(SYNC),
        .TICK_W     (TICK_W_SIM),
        .STABLE_N   (STABLE),
        .LONG_N     (LONGN),
        .LONG_W     (8)
    ) dut (
        .clk      (clk),
        .rst_async(rst_async),
        .switch_i (switch_i),
        .level_o  (level_o),
        .rise_o   (rise_o),
        .fall_o   (fall_o),
        .long_o   (long_o),
        .tick_o   (tick_o)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: cycle index since reset release, raw input history,
    // per-tick synchronized samples; level flips once the last STABLE samples
    // all disagree with it; long pulse when LONGN ticks have passed while high.
    int         cyc;
    logic [1:0] hist[$];
    logic [1:0] tsamp[$];
    logic [1:0] m_lvl, m_rise, m_fall, m_long;
    int         hi[2];

    logic [1:0] seen_rise, seen_fall, seen_long, last_lvl, first_rise_val;
    bit         both_rise;
    int         first_rise;

    typedef struct {
        logic [1:0] sw;
        int         cycles;
        logic [1:0] lvl;
        logic [1:0] rise;
        logic [1:0] fall;
        logic [1:0] lng;
    } vec_t;
    vec_t tbl[9];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        cyc = 0;
        hist.delete();
        tsamp.delete();
        m_lvl  = '0;
        m_rise = '0;
        m_fall = '0;
        m_long = '0;
        hi[0]  = 0;
        hi[1]  = 0;
    endfunction

    function automatic void model_step();
        logic [1:0] sync;
        bit         flip;
        sync   = (cyc >= SYNC) ? hist[cyc-SYNC] : 2'b00;
        m_rise = '0;
        m_fall = '0;
        m_long = '0;
        if ((cyc % TickP) == 0) begin
            tsamp.push_back(sync);
            for (int k = 0; k < W; k++) begin
                flip = (tsamp.size() >= STABLE);
                if (flip) begin
                    for (int j = 0; j < STABLE; j++) begin
                        if (tsamp[tsamp.size()-1-j][k] == m_lvl[k]) flip = 1'b0;
                    end
                end
                if (flip) begin
                    m_lvl[k] = ~m_lvl[k];
                    if (m_lvl[k]) m_rise[k] = 1'b1;
                    else          m_fall[k] = 1'b1;
                    hi[k] = 0;
                end else if (m_lvl[k]) begin
                    hi[k]++;
                    if (hi[k] == LONGN) m_long[k] = 1'b1;
                end
            end
        end
        cyc++;
    endfunction

    // One clock: drive just after posedge, compare at negedge, advance model
    task automatic step(input logic [1:0] sw);
        logic tk;
        switch_i = sw;
        hist.push_back(sw);
        @(negedge clk);
        tk = ((cyc % TickP) == 0);
        check("cycle_outputs", 32'({level_o, rise_o, fall_o, long_o, tick_o}),
              32'({m_lvl, m_rise, m_fall, m_long, tk}));
        seen_rise |= rise_o;
        seen_fall |= fall_o;
        seen_long |= long_o;
        last_lvl   = level_o;
        if (rise_o == 2'b11) both_rise = 1'b1;
        if (rise_o != 2'b00 && first_rise < 0) begin
            first_rise     = cyc;
            first_rise_val = rise_o;
        end
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset(input bit mid);
        if (mid) begin
            #2;
            rst_async = 1'b1;
            #1;
            check("async_reset_outputs", 32'({level_o, rise_o, fall_o, long_o, tick_o}), 32'h0);
        end else begin
            rst_async = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        rst_async = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [1:0] sw;

        // Hand-derived from cycle 0 = first cycle after release (tick at 0,4,8..)
        tbl[0] = '{2'b00, 12, 2'b00, 2'b00, 2'b00, 2'b00};
        tbl[1] = '{2'b01, 16, 2'b01, 2'b01, 2'b00, 2'b00}; // rise at cycle 25
        tbl[2] = '{2'b01, 20, 2'b01, 2'b00, 2'b00, 2'b01}; // long at cycle 41
        tbl[3] = '{2'b01, 40, 2'b01, 2'b00, 2'b00, 2'b00}; // no repeat long
        tbl[4] = '{2'b00, 16, 2'b00, 2'b00, 2'b01, 2'b00}; // fall at cycle 101
        tbl[5] = '{2'b01,  8, 2'b00, 2'b00, 2'b00, 2'b00}; // 2-tick glitch
        tbl[6] = '{2'b00, 20, 2'b00, 2'b00, 2'b00, 2'b00};
        tbl[7] = '{2'b11, 16, 2'b11, 2'b11, 2'b00, 2'b00}; // joint rise at 145
        tbl[8] = '{2'b00, 16, 2'b00, 2'b00, 2'b11, 2'b00}; // fall before long

        do_reset(1'b0);
        for (int i = 0; i < 9; i++) begin
            seen_rise  = '0;
            seen_fall  = '0;
            seen_long  = '0;
            both_rise  = 1'b0;
            first_rise = -1;
            repeat (tbl[i].cycles) step(tbl[i].sw);
            check($sformatf("vec%0d_level", i), 32'(last_lvl), 32'(tbl[i].lvl));
            check($sformatf("vec%0d_rise", i), 32'(seen_rise), 32'(tbl[i].rise));
            check($sformatf("vec%0d_fall", i), 32'(seen_fall), 32'(tbl[i].fall));
            check($sformatf("vec%0d_long", i), 32'(seen_long), 32'(tbl[i].lng));
            if (i == 7) check("vec7_same_cycle_rise", 32'(both_rise), 32'd1);
        end

        // Reset while ch0 has two qualifying ticks pending and ch1 is high
        do_reset(1'b0);
        repeat (16) step(2'b10);
        check("pre_reset_level", 32'(last_lvl), 32'(2'b10));
        repeat (10) step(2'b11);
        do_reset(1'b1);
        first_rise = -1;
        repeat (20) step(2'b11);
        check("restart_rise_cycle", 32'(first_rise), 32'd13);
        check("restart_rise_value", 32'(first_rise_val), 32'(2'b11));

        // Random run: each bit flips rarely so both glitches and holds occur
        do_reset(1'b0);
        sw = 2'b00;
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < W; k++) begin
                if ($urandom_range(0, 15) == 0) sw[k] = ~sw[k];
            end
            step(sw);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
